pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter and instruction-fetch stage of the datapath. Holds the 32-bit PC and drives `pc_mas4` into the zero-flag next-PC multiplexer's `cero` input. Consumes that multiplexer's `salida` as the next PC. Runs a valid/ack handshake with instruction memory and presents one fetched instruction at a time to decode.

## Interface
- `WIDTH`, 32, PC / instruction width
- `RESET_PC`, 32'h00000000, PC value after reset
- `STEP`, 4, sequential PC increment
- `ESPERA_MAX`, 15, max cycles waiting for `mem_ack` before timeout
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `siguiente`  in  WIDTH  next PC from the ZF multiplexer `salida`
- `avance`  in  1  decode consumed current instruction
- `stall`  in  1  hold PC and instruction; dominates `avance`
- `pc`  out  WIDTH  current PC
- `pc_mas4`  out  WIDTH  `pc + STEP`, to multiplexer `cero`
- `mem_req`  out  1  fetch request
- `mem_addr`  out  WIDTH  fetch address, equals `pc`
- `mem_ack`  in  1  memory returns `mem_dato`
- `mem_dato`  in  WIDTH  instruction word
- `instr`  out  WIDTH  latched instruction
- `instr_valida`  out  1  `instr` valid for decode
- `error_mem`  out  1  fetch timeout, sticky
- `error_alin`  out  1  misaligned PC, sticky; only with macro

## Operation
- Reset values (immediate, async):
  - `pc` = `RESET_PC`, `pc_mas4` = `RESET_PC+STEP`
  - `mem_req`, `instr_valida`, `error_mem`, `error_alin` = 0
  - `instr` = 0
  - state INICIO, wait counter 0
- INICIO → REQ unconditionally on the next edge.
- REQ:
  - `mem_req`=1, `mem_addr`=`pc`; counter increments each cycle.
  - On `mem_ack`=1: latch `mem_dato` into `instr`, set `instr_valida`, clear counter, go to LISTO.
  - If counter reaches `ESPERA_MAX` without ack: go to FALLA.
- LISTO:
  - `mem_req`=0, `instr_valida`=1.
  - If `avance`=1 and `stall`=0: `pc` ← `siguiente`, `instr_valida` ← 0, go to REQ.
  - Otherwise hold all state.
- FALLA: `error_mem`=1, `mem_req`=0, `instr_valida`=0; terminal until reset.
- `mem_ack` outside REQ is ignored.
- `stall`=1 in REQ does not cancel an outstanding request; it only blocks PC update in LISTO.
- Arithmetic is unsigned modulo 2^WIDTH: `pc`=32'hFFFFFFFC gives `pc_mas4`=32'h00000000.
- `siguiente` is sampled only on the LISTO→REQ edge.

## Timing
- `pc_mas4` is combinational from `pc`: zero latency.
- All other outputs are registered.
- `mem_req` rises one cycle after reset release.
- Ack sampled on edge N: `instr_valida` high and `mem_req` low after edge N.
- Minimum issue-to-issue time is 2 cycles (ack same cycle as request, `avance` in the first LISTO cycle).
- Timeout: `error_mem` rises `ESPERA_MAX` cycles after entering REQ.
- A reset mid-fetch discards the request; no `instr_valida` pulse follows.

## Configuration
- Macro: `PC_ALIGN_CHECK_EN`.
- Defined:
  - If `siguiente[1:0]` ≠ 0 on the LISTO→REQ edge, `pc` is not updated.
  - State goes to FALLA with `error_alin`=1 and `error_mem`=0.
- Undefined:
  - No check; `siguiente` is loaded as-is.
  - `error_alin` is tied to 0.

## Structure
- Shared package `datapath_pkg`:
  - state encoding (INICIO, REQ, LISTO, FALLA)
  - `PC_STEP` and default `RESET_PC` constants
- Sub-module `pc_registro`: WIDTH-bit register with async active-low reset to `RESET_PC` and a load enable. It is instantiated once for `pc`.

## Test plan
- Reset, release, `mem_ack` held 1, `mem_dato`=32'h8C010004 → `mem_addr`=0, `instr`=32'h8C010004, `instr_valida`=1 two cycles after release.
- In LISTO, `siguiente`=`pc_mas4`, `avance`=1, three times → `mem_addr` sequence 0, 4, 8, C.
- `siguiente`=32'h00000040 (branch taken), `avance`=1 and `stall`=1 for 3 cycles, then `stall`=0 → PC held at 0 for 3 cycles, then `mem_addr`=32'h40.
- `pc`=32'hFFFFFFFC → `pc_mas4`=0; advancing fetches address 0.
- `mem_ack` held 0 → `error_mem`=1 after 15 cycles, `mem_req`=0, state persists until `rst_n`=0.
- With `PC_ALIGN_CHECK_EN`, `siguiente`=32'h00000042 plus `avance` → `error_alin`=1 and `pc` unchanged. Without the macro, `mem_addr`=32'h42.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared datapath definitions: fetch FSM state encoding and PC constants.
package datapath_pkg;

  typedef enum logic [1:0] {
    StInicio = 2'd0,
    StReq    = 2'd1,
    StListo  = 2'd2,
    StFalla  = 2'd3
  } estado_e;

  localparam int unsigned PC_STEP      = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/pc_registro.sv
// WIDTH-bit register with asynchronous active-low reset to RESET_PC and load enable.
module pc_registro #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             carga_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RESET_PC;
    end else if (carga_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC and instruction-fetch stage with valid/ack memory handshake and fetch timeout.
// Optional misaligned-PC trap enabled by defining PC_ALIGN_CHECK_EN.
module pc_fetch_unit
  import datapath_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(RESET_PC_DEF),
  parameter int unsigned      STEP       = PC_STEP,
  parameter int unsigned      ESPERA_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] siguiente,
  input  logic             avance,
  input  logic             stall,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_mas4,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_dato,
  output logic [WIDTH-1:0] instr,
  output logic             instr_valida,
  output logic             error_mem,
  output logic             error_alin
);

  localparam int unsigned    CntW   = $clog2(ESPERA_MAX + 1);
  localparam logic [CntW-1:0] CntUlt = CntW'(ESPERA_MAX - 1);

  estado_e          estado_q;
  logic [CntW-1:0]  cnt_q;
  logic             mem_req_q;
  logic [WIDTH-1:0] instr_q;
  logic             valida_q;
  logic             err_mem_q;
  logic             avanza;
  logic             alin_ok;
  logic             pc_carga;

  assign avanza = (estado_q == StListo) && avance && !stall;

`ifdef PC_ALIGN_CHECK_EN
  logic err_alin_q;
  assign alin_ok    = (siguiente[1:0] == 2'b00);
  assign error_alin = err_alin_q;
`else
  assign alin_ok    = 1'b1;
  assign error_alin = 1'b0;
`endif

  assign pc_carga = avanza && alin_ok;

  pc_registro #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_registro (
    .clk     (clk),
    .rst_n   (rst_n),
    .carga_i (pc_carga),
    .d_i     (siguiente),
    .q_o     (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= StInicio;
      cnt_q     <= '0;
      mem_req_q <= 1'b0;
      instr_q   <= '0;
      valida_q  <= 1'b0;
      err_mem_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      err_alin_q <= 1'b0;
`endif
    end else begin
      unique case (estado_q)
        StInicio: begin
          estado_q  <= StReq;
          mem_req_q <= 1'b1;
          cnt_q     <= '0;
        end
        StReq: begin
          // Ack wins over timeout when both land on the last waiting cycle.
          if (mem_ack) begin
            instr_q   <= mem_dato;
            valida_q  <= 1'b1;
            mem_req_q <= 1'b0;
            cnt_q     <= '0;
            estado_q  <= StListo;
          end else if (cnt_q == CntUlt) begin
            mem_req_q <= 1'b0;
            err_mem_q <= 1'b1;
            estado_q  <= StFalla;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StListo: begin
          if (avanza) begin
            valida_q <= 1'b0;
            if (alin_ok) begin
              mem_req_q <= 1'b1;
              estado_q  <= StReq;
            end else begin
`ifdef PC_ALIGN_CHECK_EN
              err_alin_q <= 1'b1;
`endif
              estado_q <= StFalla;
            end
          end
        end
        StFalla: begin
          mem_req_q <= 1'b0;
          valida_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pc_mas4      = pc + WIDTH'(STEP);
  assign mem_addr     = pc;
  assign mem_req      = mem_req_q;
  assign instr        = instr_q;
  assign instr_valida = valida_q;
  assign error_mem    = err_mem_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized self-checking bench for pc_fetch_unit against a transaction-level PC/instruction model.
module tb_pc_fetch_unit;

  localparam int unsigned ESPERA = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] siguiente;
  logic        avance, stall, mem_ack;
  logic [31:0] mem_dato;
  logic [31:0] pc, pc_mas4, mem_addr, instr;
  logic        mem_req, instr_valida, error_mem, error_alin;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: architectural PC and the last instruction handed to decode.
  logic [31:0] pc_exp;
  logic [31:0] instr_exp;

  pc_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .siguiente    (siguiente),
    .avance       (avance),
    .stall        (stall),
    .pc           (pc),
    .pc_mas4      (pc_mas4),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_dato     (mem_dato),
    .instr        (instr),
    .instr_valida (instr_valida),
    .error_mem    (error_mem),
    .error_alin   (error_alin)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; avance = 1'b0; stall = 1'b0; mem_ack = 1'b0;
    siguiente = '0; mem_dato = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    pc_exp = 32'h0; instr_exp = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; avance = 1'b0; stall = 1'b0; mem_ack = 1'b0;
    siguiente = '0; mem_dato = '0;
    #3;
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 0", pc); end
    n_checks++; if (pc_mas4 !== 32'h4) begin n_fail++; $display("FAIL reset_pc_mas4 got %h exp 4", pc_mas4); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
    n_checks++; if (instr_valida !== 1'b0) begin n_fail++; $display("FAIL reset_valida got %b exp 0", instr_valida); end
    n_checks++; if ({error_mem, error_alin} !== 2'b00) begin n_fail++; $display("FAIL reset_errors got %b%b exp 00", error_mem, error_alin); end
    n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h exp 0", instr); end
    tick(); tick();
    // Ack already high before release must not matter outside REQ.
    mem_ack = 1'b1; mem_dato = 32'h8C01_0004;
    rst_n = 1'b1;
    tick();
    pc_exp = 32'h0; instr_exp = 32'h0;
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL first_req got req=%b addr=%h exp req=1 addr=0", mem_req, mem_addr); end
    n_checks++; if (instr_valida !== 1'b0) begin n_fail++; $display("FAIL first_req_valida got %b exp 0", instr_valida); end
  endtask

  // Precondition: just after the edge that entered REQ.
  task automatic fetch(input int espera, input logic [31:0] dato);
    for (int i = 0; i < espera; i++) begin
      mem_ack = 1'b0; mem_dato = $urandom();
      tick();
      n_checks++;
      if (mem_req !== 1'b1 || instr_valida !== 1'b0 || mem_addr !== pc_exp || error_mem !== 1'b0) begin
        n_fail++;
        $display("FAIL fetch_wait got req=%b val=%b addr=%h err=%b exp req=1 val=0 addr=%h err=0",
                 mem_req, instr_valida, mem_addr, error_mem, pc_exp);
      end
    end
    mem_ack = 1'b1; mem_dato = dato;
    tick();
    mem_ack = 1'b0;
    instr_exp = dato;
    n_checks++;
    if (instr_valida !== 1'b1 || mem_req !== 1'b0 || instr !== instr_exp) begin
      n_fail++;
      $display("FAIL fetch_ack got val=%b req=%b instr=%h exp val=1 req=0 instr=%h",
               instr_valida, mem_req, instr, instr_exp);
    end
  endtask

  // Precondition: in LISTO. Holds/stalls first, then the PC update edge.
  task automatic advance(input logic [31:0] destino, input int stalls, input int holds);
    for (int i = 0; i < holds + stalls; i++) begin
      siguiente = destino;
      avance    = (i >= holds);
      stall     = (i >= holds) ? 1'b1 : 1'b0;
      mem_ack   = $urandom_range(0, 1);
      mem_dato  = $urandom();
      tick();
      n_checks++;
      if (pc !== pc_exp || instr_valida !== 1'b1 || mem_req !== 1'b0 || instr !== instr_exp) begin
        n_fail++;
        $display("FAIL listo_hold got pc=%h val=%b req=%b instr=%h exp pc=%h val=1 req=0 instr=%h",
                 pc, instr_valida, mem_req, instr, pc_exp, instr_exp);
      end
    end
    mem_ack = 1'b0; siguiente = destino; avance = 1'b1; stall = 1'b0;
    tick();
    avance = 1'b0; siguiente = $urandom();
    pc_exp = destino;
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== pc_exp || instr_valida !== 1'b0 || pc_mas4 !== pc_exp + 32'd4) begin
      n_fail++;
      $display("FAIL advance got req=%b addr=%h val=%b mas4=%h exp req=1 addr=%h val=0 mas4=%h",
               mem_req, mem_addr, instr_valida, pc_mas4, pc_exp, pc_exp + 32'd4);
    end
  endtask

  task automatic test_first_fetch();
    fetch(0, 32'h8C01_0004);
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 3; k++) begin
      advance(pc_exp + 32'd4, 0, 0);
      fetch($urandom_range(0, 3), $urandom());
    end
    n_checks++; if (pc !== 32'hC) begin n_fail++; $display("FAIL seq_pc got %h exp c", pc); end
  endtask

  task automatic test_stall_branch();
    advance(32'h0000_0040, 3, 0);
    fetch(ESPERA - 1, $urandom());
  endtask

  task automatic test_wrap();
    advance(32'hFFFF_FFFC, 0, 1);
    n_checks++; if (pc_mas4 !== 32'h0) begin n_fail++; $display("FAIL wrap_mas4 got %h exp 0", pc_mas4); end
    fetch(1, $urandom());
    advance(pc_exp + 32'd4, 0, 0);
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr got %h exp 0", mem_addr); end
    fetch(0, $urandom());
  endtask

  task automatic test_random();
    logic [31:0] destino;
    for (int k = 0; k < 20; k++) begin
      destino = ($urandom_range(0, 1) == 1) ? pc_exp + 32'd4 : ($urandom() & 32'hFFFF_FFFC);
      advance(destino, $urandom_range(0, 3), $urandom_range(0, 2));
      fetch($urandom_range(0, ESPERA - 1), $urandom());
    end
  endtask

  task automatic test_misaligned();
    siguiente = 32'h0000_0042; avance = 1'b1; stall = 1'b0;
    tick();
    avance = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (error_alin !== 1'b1 || error_mem !== 1'b0 || pc !== pc_exp || mem_req !== 1'b0 || instr_valida !== 1'b0) begin
        n_fail++;
        $display("FAIL misaligned got alin=%b mem=%b pc=%h req=%b val=%b exp alin=1 mem=0 pc=%h req=0 val=0",
                 error_alin, error_mem, pc, mem_req, instr_valida, pc_exp);
      end
      avance = 1'b1; siguiente = pc_exp;
      tick();
      avance = 1'b0;
    end
`else
    pc_exp = 32'h0000_0042;
    n_checks++;
    if (mem_addr !== 32'h42 || mem_req !== 1'b1 || error_alin !== 1'b0) begin
      n_fail++;
      $display("FAIL misaligned got addr=%h req=%b alin=%b exp addr=42 req=1 alin=0", mem_addr, mem_req, error_alin);
    end
    fetch(2, $urandom());
`endif
  endtask

  task automatic test_timeout();
    int n;
    apply_reset();
    n = 0;
    while (error_mem !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    n_checks++; if (n != ESPERA) begin n_fail++; $display("FAIL timeout_cycles got %0d exp %0d", n, ESPERA); end
    for (int i = 0; i < 5; i++) begin
      mem_ack = 1'b1; mem_dato = $urandom(); avance = 1'b1;
      tick();
      n_checks++;
      if (error_mem !== 1'b1 || mem_req !== 1'b0 || instr_valida !== 1'b0 || error_alin !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_sticky got err=%b req=%b val=%b alin=%b exp err=1 req=0 val=0 alin=0",
                 error_mem, mem_req, instr_valida, error_alin);
      end
    end
    mem_ack = 1'b0; avance = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (error_mem !== 1'b0) begin n_fail++; $display("FAIL timeout_clear got %b exp 0", error_mem); end
  endtask

  task automatic test_reset_mid_fetch();
    apply_reset();
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL midreset_req got %b exp 0", mem_req); end
    mem_ack = 1'b1; mem_dato = 32'hDEAD_BEEF;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    mem_ack = 1'b0;
    n_checks++;
    if (instr_valida !== 1'b0 || instr !== 32'h0 || mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_after got val=%b instr=%h req=%b exp val=0 instr=0 req=1", instr_valida, instr, mem_req);
    end
    tick();
    n_checks++; if (instr_valida !== 1'b0) begin n_fail++; $display("FAIL midreset_nopulse got %b exp 0", instr_valida); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_sequential();
    test_stall_branch();
    test_wrap();
    test_random();
    test_misaligned();
    test_timeout();
    test_reset_mid_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
